// File: rtl/io_input_cond.sv
// Two-flop synchronizer plus per-bit debounce for 32 switches and 4 buttons, with press pulses and sticky flags.
// Latency: DEBOUNCE_CYCLES+2 edges from pad to stable level; no backpressure, outputs are always valid.
module io_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  input  logic [3:0]  i_btn_evt_clr,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_press,
  output logic [3:0]  o_btn_evt
);

  localparam int NL = 36;
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    BTN_REL  = BTN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [NL-1:0] LANE_RST = {BTN_REL, 32'h0};

  logic [NL-1:0] sync1_q, sync1_d;
  logic [NL-1:0] sync2_q, sync2_d;
  logic [NL-1:0] stable_q, stable_d;
  logic [CW-1:0] cnt_q [NL];
  logic [CW-1:0] cnt_d [NL];
  logic [3:0]    press_now;
  logic [3:0]    btn_press_q, btn_press_d;
  logic [3:0]    btn_evt_q, btn_evt_d;

  always_comb begin
    sync1_d  = {i_btn_raw, i_sw_raw};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < NL; i++) begin
      cnt_d[i] = '0;
      // Any cycle agreeing with the stable level restarts the count.
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    press_now   = ~(stable_q[35:32] ^ BTN_REL) & (stable_d[35:32] ^ BTN_REL);
    btn_press_d = press_now;
    btn_evt_d   = press_now | (btn_evt_q & ~i_btn_evt_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= LANE_RST;
      sync2_q     <= LANE_RST;
      stable_q    <= LANE_RST;
      btn_press_q <= '0;
      btn_evt_q   <= '0;
      for (int i = 0; i < NL; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      btn_press_q <= btn_press_d;
      btn_evt_q   <= btn_evt_d;
      for (int i = 0; i < NL; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_io_sw     = stable_q[31:0];
  assign o_io_btn    = stable_q[35:32];
  assign o_btn_press = btn_press_q;
  assign o_btn_evt   = btn_evt_q;

endmodule

// File: doc/io_input_cond.md
# io_input_cond

Input conditioning stage for the board switches and push-buttons. It sits directly upstream of the load/store unit's switch and button read ports. Each raw asynchronous pad bit passes through a two-flop synchronizer and a per-bit debounce counter, and the stable levels are presented to the LSU. It also generates one-cycle button-press pulses and sticky per-button press flags that software can clear.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16. Number of consecutive cycles a synchronized bit must differ from its stable value before the stable value flips. Legal range is 1 or more.
- BTN_ACTIVE_LOW, default 1. When 1, a press is a stable 1→0 transition and the released level is 1. When 0, a press is 0→1 and the released level is 0.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- i_sw_raw  input  32  raw switch pads, asynchronous to clk.
- i_btn_raw  input  4  raw button pads, asynchronous to clk.
- i_btn_evt_clr  input  4  per-bit clear of o_btn_evt, sampled at posedge.
- o_io_sw  output  32  debounced switch levels; drives the LSU switch read port.
- o_io_btn  output  4  debounced button levels, raw polarity preserved; drives the LSU button read port.
- o_btn_press  output  4  one-cycle pulse per button on a debounced press.
- o_btn_evt  output  4  sticky press flags.

## Operation
- There are 36 identical conditioning lanes: 32 switch lanes and 4 button lanes. Each lane holds sync1, sync2, stable and cnt.
- Synchronizer: sync1 <= raw, then sync2 <= sync1.
- Debounce rule, evaluated on every posedge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Any cycle in which sync2 matches stable restarts the count. A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 therefore never reaches stable.
- cnt is $clog2(DEBOUNCE_CYCLES)+1 bits wide and never wraps, because it is cleared at DEBOUNCE_CYCLES-1.
- o_io_sw and o_io_btn are the stable registers, driven directly with no combinational logic on the output path.
- Press detect:
  - o_btn_press[i] <= 1 at the same edge where stable_btn[i] moves from released to pressed level.
  - Otherwise o_btn_press[i] <= 0.
  - A release produces no pulse.
- Sticky flags: o_btn_evt[i] <= press_now[i] | (o_btn_evt[i] & ~i_btn_evt_clr[i]).
  - press_now is the same condition that sets o_btn_press.
  - If a press and a clear occur at the same edge, set wins.
- Lanes are fully independent. Simultaneous changes on several bits each follow their own counter.

## Timing
- Reset values when rst_n = 0 at a posedge:
  - Switch lanes: sync1, sync2 and stable are 0.
  - Button lanes: sync1, sync2 and stable are 4'hF when BTN_ACTIVE_LOW = 1, else 4'h0.
  - All cnt = 0.
  - o_io_sw = 32'h0.
  - o_io_btn = the released level.
  - o_btn_press = 0.
  - o_btn_evt = 0.
- Reset asserted mid-count discards the count. No stable change and no pulse occurs from the pre-reset count.
- Latency: raw changes before edge 1 and holds. sync2 shows the new value after edge 2, and stable flips at edge 2+DEBOUNCE_CYCLES. The total is DEBOUNCE_CYCLES+2 edges.
- o_btn_press is high for exactly one cycle, aligned with the cycle in which o_io_btn first shows the pressed level.
- o_btn_evt rises in that same cycle. It falls on the edge after clr is sampled, provided no press occurs at that edge.
- A button held pressed through reset release is not suppressed. It debounces from the released reset state, so it yields one press pulse DEBOUNCE_CYCLES+2 edges after rst_n deasserts.
- The LSU reads o_io_sw and o_io_btn combinationally. This block adds no handshake, and the outputs are always valid.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and BTN_ACTIVE_LOW = 1.
- Reset: hold rst_n low for 2 cycles with i_sw_raw = 32'hFFFF_FFFF. Required: o_io_sw = 0, o_io_btn = 4'hF, o_btn_press = 0, o_btn_evt = 0. After release, o_io_sw = 32'hFFFF_FFFF exactly 6 edges later.
- Switch latency: set i_sw_raw from 0 to 32'hA5A5_0001 before edge 1 and hold. Required: o_io_sw stays 0 through edge 5 and becomes 32'hA5A5_0001 at edge 6. o_btn_press stays 0 throughout.
- Glitch rejection: drive i_sw_raw[3] high for 3 cycles, then low. Separately, drive a bounce on i_btn_raw[2] that alternates every 2 cycles for 20 cycles. Required: o_io_sw and o_io_btn never change, and o_btn_press stays 0.
- Button press: drive i_btn_raw from 4'hF to 4'hE and hold for 12 cycles, then back to 4'hF. Required:
  - o_io_btn = 4'hE at edge 6.
  - o_btn_press = 4'h1 for exactly one cycle.
  - o_btn_evt = 4'h1 and it stays set after release.
  - The release causes no second pulse.
- Clear vs set: with o_btn_evt = 4'h1, pulse i_btn_evt_clr = 4'h1 → o_btn_evt = 0 next cycle. Then assert i_btn_evt_clr = 4'h2 on the same edge that button 1 press completes → o_btn_evt = 4'h2, because set wins.
- Reset mid-debounce: start a press on button 3, then assert rst_n low after 2 counter cycles and hold it for 1 cycle. Required: o_io_btn = 4'hF, and no o_btn_press pulse appears from the pre-reset count.
